// File: rtl/axi_lite_reg_bank_param.sv
// axi_lite_reg_bank_param: parametrised AXI4-Lite slave register bank.
// RW control registers with byte strobes, RO status registers fed from
// fabric, per-register one-cycle write pulses, and SLVERR on writes to RO
// or out-of-range addresses and on out-of-range reads.
module axi_lite_reg_bank_param #(
  parameter int unsigned           C_DATA_WIDTH = 32,
  parameter int unsigned           C_NUM_REGS   = 8,
  parameter int unsigned           C_ADDR_WIDTH = 6,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = 8'hC0
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  // write address channel
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  // write data channel
  input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  // write response channel
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  // read address channel
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  // read data channel
  output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  // fabric side
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
  output logic [C_NUM_REGS-1:0]              wr_pulse
);

  localparam int unsigned LP_STRB_W = C_DATA_WIDTH / 8;
  localparam int unsigned LP_LSB    = $clog2(LP_STRB_W);
  localparam int unsigned LP_IDX_W  = $clog2(C_NUM_REGS);
  localparam int unsigned LP_TOP    = LP_LSB + LP_IDX_W;

  localparam logic [1:0] LP_OKAY   = 2'b00;
  localparam logic [1:0] LP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Any set address bit above the register index field is out of range.
  function automatic logic f_oor(input logic [C_ADDR_WIDTH-1:0] a);
    return (a >> LP_TOP) != '0;
  endfunction

  // ---------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------
  logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] w_regs;
  logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] w_status;
  logic [C_NUM_REGS-1:0]                   w_wr_en;
  logic [C_ADDR_WIDTH-1:0]                 w_awaddr_eff;
  logic [C_DATA_WIDTH-1:0]                 w_wdata_eff;
  logic [LP_STRB_W-1:0]                    w_wstrb_eff;

  assign w_status = status_in;
  assign reg_out  = w_regs;

  for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
    if (C_RO_MASK[gi]) begin : g_ro
      assign w_regs[gi] = '0;
    end else begin : g_rw
      logic [C_DATA_WIDTH-1:0] r_reg;
      // byte-lane update on a committed write to this register
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          r_reg <= '0;
        end else if (w_wr_en[gi]) begin
          for (int unsigned b = 0; b < LP_STRB_W; b++) begin
            if (w_wstrb_eff[b]) r_reg[b*8 +: 8] <= w_wdata_eff[b*8 +: 8];
          end
        end
      end
      assign w_regs[gi] = r_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  wstate_t                 r_wstate, w_wstate_nxt;
  logic                    r_aw_held, r_w_held;
  logic [C_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_DATA_WIDTH-1:0] r_wdata;
  logic [LP_STRB_W-1:0]    r_wstrb;
  logic [1:0]              r_bresp;
  logic [C_NUM_REGS-1:0]   r_wr_pulse;
  logic                    w_awready, w_wready, w_aw_hs, w_w_hs, w_commit;
  logic [LP_IDX_W-1:0]     w_widx;
  logic                    w_wok;

  // Commit uses the held beat if one was captured earlier, otherwise the
  // beat handshaking in this cycle.
  assign w_awaddr_eff = r_aw_held ? r_awaddr : S_AXI_AWADDR;
  assign w_wdata_eff  = r_w_held  ? r_wdata  : S_AXI_WDATA;
  assign w_wstrb_eff  = r_w_held  ? r_wstrb  : S_AXI_WSTRB;
  assign w_widx       = w_awaddr_eff[LP_LSB +: LP_IDX_W];
  assign w_wok        = !f_oor(w_awaddr_eff) && !C_RO_MASK[w_widx];

  // write FSM next state, ready signals and commit detection
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = !r_aw_held;
        w_wready  = !r_w_held;
        w_aw_hs   = S_AXI_AWVALID && !r_aw_held;
        w_w_hs    = S_AXI_WVALID && !r_w_held;
        if ((w_aw_hs || r_aw_held) && (w_w_hs || r_w_held)) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  // one-hot register write enable for a legal committed write
  always_comb begin
    w_wr_en = '0;
    for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
      w_wr_en[i] = w_commit && w_wok && (w_widx == LP_IDX_W'(i));
    end
  end

  // write FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // AW/W holding registers; flags clear on the B handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (r_wstate == W_IDLE) begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
    end else if (S_AXI_BREADY) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end
  end

  // write response and single-cycle write pulses
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bresp    <= LP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_wr_en;
      if (w_commit) r_bresp <= w_wok ? LP_OKAY : LP_SLVERR;
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = (r_wstate == W_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign wr_pulse      = r_wr_pulse;

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  rstate_t                 r_rstate, w_rstate_nxt;
  logic [C_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]              r_rresp;
  logic                    w_arready, w_ar_hs;
  logic [LP_IDX_W-1:0]     w_ridx;
  logic [C_DATA_WIDTH-1:0] w_rd_val;

  assign w_ridx   = S_AXI_ARADDR[LP_LSB +: LP_IDX_W];
  assign w_rd_val = C_RO_MASK[w_ridx] ? w_status[w_ridx] : w_regs[w_ridx];

  // read FSM next state and AR ready
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_ar_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        w_ar_hs   = S_AXI_ARVALID;
        if (w_ar_hs) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  // read FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  // read data capture on the AR handshake; pre-write value on a same-edge write
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rdata <= '0;
      r_rresp <= LP_OKAY;
    end else if (w_ar_hs) begin
      if (f_oor(S_AXI_ARADDR)) begin
        r_rdata <= '0;
        r_rresp <= LP_SLVERR;
      end else begin
        r_rdata <= w_rd_val;
        r_rresp <= LP_OKAY;
      end
    end
  end

  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = (r_rstate == R_DATA);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

  // protection bits and sub-word address bits carry no meaning here
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                      r_awaddr, status_in};

endmodule

// File: tb/tb_axi_lite_reg_bank_param.sv
// Directed bench for axi_lite_reg_bank_param at default parameters
// (32-bit data, 8 registers, 6-bit address, registers 6 and 7 read-only).
module tb_axi_lite_reg_bank_param;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [5:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready;
  logic [255:0] reg_out;
  logic [255:0] status_in;
  logic [7:0]   wr_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_lite_reg_bank_param #(
    .C_DATA_WIDTH(32),
    .C_NUM_REGS  (8),
    .C_ADDR_WIDTH(6),
    .C_RO_MASK   (8'hC0)
  ) dut (
    .ACLK         (clk),
    .ARESETN      (rst_n),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .reg_out      (reg_out),
    .status_in    (status_in),
    .wr_pulse     (wr_pulse)
  );

  // Full write transaction; returns BRESP and the OR of wr_pulse seen.
  task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output logic [7:0] pulses);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0; pulses = '0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; n++;
      pulses |= wr_pulse;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      n_checks++;
      $display("FAIL write_handshake_timeout addr=%h got aw=%0d w=%0d want 1 1", a, aw_done, w_done);
    end
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; pulses |= wr_pulse; end
    if (!bvalid) begin
      n_checks++;
      $display("FAIL bvalid_timeout addr=%h got bvalid=0 want 1", a);
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    pulses |= wr_pulse;
    bready = 1'b0;
  endtask

  // Full read transaction.
  task automatic do_read(input logic [5:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    int n;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      n_checks++;
      $display("FAIL rvalid_timeout addr=%h got rvalid=0 want 1", a);
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (reg_out !== '0) $display("FAIL reset_reg_out got=%h want=0", reg_out);
    else n_pass++;
    n_checks++;
    if ({bvalid, rvalid, wr_pulse, bresp, rresp, rdata} !== '0)
      $display("FAIL reset_outputs got bvalid=%b rvalid=%b wr_pulse=%h bresp=%b rresp=%b rdata=%h want all 0",
               bvalid, rvalid, wr_pulse, bresp, rresp, rdata);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL reset_readies got aw/w/ar=%b want 111", {awready, wready, arready});
    else n_pass++;
  endtask

  task automatic test_defaults();
    logic [1:0]  resp;
    logic [7:0]  p;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      do_write(6'(i * 4), 32'(i + 1), 4'hF, resp, p);
      n_checks++;
      if (resp !== 2'b00) $display("FAIL defaults_bresp idx=%0d got=%b want=00", i, resp);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      do_read(6'(i * 4), d, resp);
      n_checks++;
      if (d !== 32'(i + 1) || resp !== 2'b00)
        $display("FAIL defaults_read idx=%0d got data=%h resp=%b want data=%h resp=00", i, d, resp, i + 1);
      else n_pass++;
    end
    n_checks++;
    if (reg_out[127:0] !== {32'h4, 32'h3, 32'h2, 32'h1})
      $display("FAIL defaults_reg_out got=%h want=%h", reg_out[127:0], {32'h4, 32'h3, 32'h2, 32'h1});
    else n_pass++;
  endtask

  task automatic test_strobe();
    logic [1:0]  resp;
    logic [7:0]  p;
    logic [31:0] d;
    do_write(6'h10, 32'h11223344, 4'hF, resp, p);
    do_write(6'h10, 32'hAABBCCDD, 4'b0101, resp, p);
    do_read(6'h10, d, resp);
    n_checks++;
    if (d !== 32'h11BB33DD || resp !== 2'b00)
      $display("FAIL strobe_read got data=%h resp=%b want data=11bb33dd resp=00", d, resp);
    else n_pass++;
  endtask

  task automatic test_w_before_aw();
    @(posedge clk); #1;
    wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    n_checks++;
    if (wready !== 1'b0 || awready !== 1'b1)
      $display("FAIL wfirst_readies got wready=%b awready=%b want 0 1", wready, awready);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (bvalid !== 1'b0) $display("FAIL wfirst_early_bvalid got=%b want=0", bvalid);
    else n_pass++;
    awaddr = 6'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_pulse !== 8'h04)
      $display("FAIL wfirst_commit got bvalid=%b bresp=%b wr_pulse=%h want 1 00 04", bvalid, bresp, wr_pulse);
    else n_pass++;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0 || wr_pulse !== 8'h00 || reg_out[64 +: 32] !== 32'h77)
      $display("FAIL wfirst_after got bvalid=%b wr_pulse=%h reg2=%h want 0 00 00000077",
               bvalid, wr_pulse, reg_out[64 +: 32]);
    else n_pass++;
  endtask

  task automatic test_status_errors();
    logic [1:0]  resp;
    logic [7:0]  p;
    logic [31:0] d;
    status_in[6*32 +: 32] = 32'hDEADBEEF;
    status_in[1*32 +: 32] = 32'h12345678;
    do_read(6'h18, d, resp);
    n_checks++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00)
      $display("FAIL status_read got data=%h resp=%b want deadbeef 00", d, resp);
    else n_pass++;
    do_write(6'h18, 32'hFFFF_FFFF, 4'hF, resp, p);
    n_checks++;
    if (resp !== 2'b10 || p !== 8'h00 || reg_out[192 +: 64] !== '0)
      $display("FAIL ro_write got resp=%b pulses=%h reg67=%h want 10 00 0", resp, p, reg_out[192 +: 64]);
    else n_pass++;
    do_write(6'h24, 32'hFFFF_FFFF, 4'hF, resp, p);
    n_checks++;
    if (resp !== 2'b10 || p !== 8'h00 || reg_out[32 +: 32] !== 32'h2)
      $display("FAIL oor_write got resp=%b pulses=%h reg1=%h want 10 00 00000002", resp, p, reg_out[32 +: 32]);
    else n_pass++;
    do_read(6'h24, d, resp);
    n_checks++;
    if (d !== 32'h0 || resp !== 2'b10)
      $display("FAIL oor_read got data=%h resp=%b want 0 10", d, resp);
    else n_pass++;
    do_read(6'h04, d, resp);
    n_checks++;
    if (d !== 32'h2) $display("FAIL rw_ignores_status got=%h want=00000002", d);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d_hold;
    @(posedge clk); #1;
    awaddr = 6'h14; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    awaddr = 6'h04;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0)
        $display("FAIL b_stall cyc=%0d got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                 c, bvalid, bresp, awready, wready);
      else n_pass++;
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1)
      $display("FAIL b_release got bvalid=%b awready=%b want 0 1", bvalid, awready);
    else n_pass++;
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = 32'h99; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    n_checks++;
    if (bvalid !== 1'b1 || wr_pulse !== 8'h02)
      $display("FAIL second_aw got bvalid=%b wr_pulse=%h want 1 02", bvalid, wr_pulse);
    else n_pass++;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_checks++;
    if (reg_out[32 +: 32] !== 32'h99 || reg_out[160 +: 32] !== 32'h55)
      $display("FAIL second_aw_regs got reg1=%h reg5=%h want 00000099 00000055",
               reg_out[32 +: 32], reg_out[160 +: 32]);
    else n_pass++;
    araddr = 6'h14; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    araddr = 6'h00;
    d_hold = 32'h55;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== d_hold || rresp !== 2'b00 || arready !== 1'b0)
        $display("FAIL r_stall cyc=%0d got rvalid=%b rdata=%h rresp=%b arready=%b want 1 %h 00 0",
                 c, rvalid, rdata, rresp, arready, d_hold);
      else n_pass++;
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1)
      $display("FAIL r_release got rvalid=%b arready=%b want 0 1", rvalid, arready);
    else n_pass++;
  endtask

  task automatic test_same_edge();
    @(posedge clk); #1;
    awaddr = 6'h00; wdata = 32'hAB; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h00; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1 || bvalid !== 1'b1)
      $display("FAIL same_edge got rvalid=%b rdata=%h bvalid=%b want 1 00000001 1", rvalid, rdata, bvalid);
    else n_pass++;
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    n_checks++;
    if (reg_out[31:0] !== 32'hAB) $display("FAIL same_edge_reg got=%h want=000000ab", reg_out[31:0]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [1:0]  resp;
    logic [7:0]  p;
    logic [31:0] d;
    @(posedge clk); #1;
    awaddr = 6'h0C; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h77)
      $display("FAIL pre_reset got bvalid=%b rvalid=%b rdata=%h want 1 1 00000077", bvalid, rvalid, rdata);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bvalid, rvalid, wr_pulse, bresp, rresp, rdata} !== '0 || reg_out !== '0)
      $display("FAIL async_reset got bvalid=%b rvalid=%b wr_pulse=%h rdata=%h reg_out=%h want all 0",
               bvalid, rvalid, wr_pulse, rdata, reg_out);
    else n_pass++;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_write(6'h00, 32'h5, 4'hF, resp, p);
    n_checks++;
    if (resp !== 2'b00 || p !== 8'h01 || reg_out[31:0] !== 32'h5)
      $display("FAIL post_reset_write got resp=%b pulses=%h reg0=%h want 00 01 00000005", resp, p, reg_out[31:0]);
    else n_pass++;
    do_read(6'h00, d, resp);
    n_checks++;
    if (d !== 32'h5 || resp !== 2'b00)
      $display("FAIL post_reset_read got data=%h resp=%b want 00000005 00", d, resp);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status_in = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_defaults();
    test_strobe();
    test_w_before_aw();
    test_status_errors();
    test_backpressure();
    test_same_edge();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
